// File: rtl/vec_cache_mem_slice_pkg.sv
// Shared command format and field widths for the vector-cache data ring.
// Every slice and the ring fabric around it import this package.
package vector_cache_pkg;

    localparam int BLOCK_ID_W = 4;
    localparam int CHAN_ID_W  = 1;
    localparam int CMD_ADDR_W = 10;
    localparam int TXNID_W    = 6;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2,
        OP_RSVD = 2'd3
    } mem_opcode_e;

    typedef struct packed {
        mem_opcode_e             opcode;
        logic [BLOCK_ID_W-1:0]   block_id;
        logic [CHAN_ID_W-1:0]    channel_id;
        logic [CMD_ADDR_W-1:0]   addr;
        logic [TXNID_W-1:0]      txnid;
    } mem_cmd_t;

endpackage

// File: rtl/vec_cache_mem_slice_sram.sv
// Single-port SRAM bank: write-enable, synchronous read with one cycle latency.
// No reset; read data holds its last value when the bank is idle or writing.
module vec_cache_sram_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/vec_cache_mem_slice.sv
// Ring memory slice: serves hits on NUM_CH paired banks, forwards misses, merges reads east.
// Reads return RD_LAT cycles after the command; no backpressure, losing reads are NACKed.
module vec_cache_mem_slice
    import vector_cache_pkg::*;
#(
    parameter int BLOCK_ID = 0,
    parameter int NUM_CH   = 8,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int RD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     rd_cmd_vld_in,
    input  mem_cmd_t              rd_cmd_in [NUM_CH],
    output logic [NUM_CH-1:0]     rd_cmd_vld_out,
    output mem_cmd_t              rd_cmd_out [NUM_CH],
    input  logic [NUM_CH-1:0]     wr_cmd_vld_in,
    input  mem_cmd_t              wr_cmd_in [NUM_CH],
    output logic [NUM_CH-1:0]     wr_cmd_vld_out,
    output mem_cmd_t              wr_cmd_out [NUM_CH],
    input  logic [NUM_CH-1:0]     wr_data_vld_in,
    input  logic [DATA_W-1:0]     wr_data_in [NUM_CH],
    output logic [NUM_CH-1:0]     wr_data_vld_out,
    output logic [DATA_W-1:0]     wr_data_out [NUM_CH],
    input  logic [NUM_CH-1:0]     rd_data_vld_in,
    input  logic [DATA_W-1:0]     rd_data_in [NUM_CH],
    input  mem_cmd_t              rd_data_cmd_in [NUM_CH],
    input  logic [NUM_CH-1:0]     rd_data_err_in,
    output logic [NUM_CH-1:0]     rd_data_vld_out,
    output logic [DATA_W-1:0]     rd_data_out [NUM_CH],
    output mem_cmd_t              rd_data_cmd_out [NUM_CH],
    output logic [NUM_CH-1:0]     rd_data_err_out,
    output logic [NUM_CH/2-1:0]   collision,
    output logic                  err_sticky,
    input  logic                  err_clr
);

    localparam int NPAIR = NUM_CH / 2;
    localparam int CW    = $clog2(NUM_CH);

    function automatic logic [CW-1:0] bank_of(input int c, input logic bsel);
        return CW'(c - c % 2) + CW'(bsel);
    endfunction

    logic [NUM_CH-1:0] rd_hit, wr_hit, rd_gnt;
    logic [NUM_CH-1:0] wr_pend_vld, wr_pend_bank;
    logic [ADDR_W-1:0] wr_pend_addr [NUM_CH];
    logic [NUM_CH-1:0] bank_en, bank_we, wr_lose, gnt_even, gnt_odd;
    logic [ADDR_W-1:0] bank_addr [NUM_CH];
    logic [DATA_W-1:0] bank_wdat [NUM_CH];
    logic [DATA_W-1:0] bank_rdat [NUM_CH];
    logic [DATA_W-1:0] chan_dout [NUM_CH];
    logic [DATA_W-1:0] out_dat [NUM_CH];
    logic [NUM_CH-1:0] p_vld [RD_LAT];
    logic [NUM_CH-1:0] p_gnt [RD_LAT];
    mem_cmd_t          p_cmd [RD_LAT][NUM_CH];
    logic [NUM_CH-1:0] loc_vld, loc_gnt, slot_coll;
    logic [NPAIR-1:0]  coll_nxt;

    always_comb begin
        rd_hit = '0;
        wr_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            rd_hit[c] = rd_cmd_vld_in[c] && (rd_cmd_in[c].block_id == BLOCK_ID_W'(BLOCK_ID));
            wr_hit[c] = wr_cmd_vld_in[c] && (wr_cmd_in[c].block_id == BLOCK_ID_W'(BLOCK_ID));
        end
    end

    assign rd_cmd_vld_out  = rd_cmd_vld_in & ~rd_hit;
    assign rd_cmd_out      = rd_cmd_in;
    assign wr_cmd_vld_out  = wr_cmd_vld_in & ~wr_hit;
    assign wr_cmd_out      = wr_cmd_in;
    // The data beat following a registered write hit belongs to this slice.
    assign wr_data_vld_out = wr_data_vld_in & ~wr_pend_vld;
    assign wr_data_out     = wr_data_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_pend_vld <= '0;
        else     wr_pend_vld <= wr_hit;
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_pend_bank[c] <= wr_cmd_in[c].channel_id;
            wr_pend_addr[c] <= wr_cmd_in[c].addr[ADDR_W-1:0];
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_bank
        localparam int   C0   = n - n % 2;
        localparam int   C1   = C0 + 1;
        localparam logic BSEL = 1'(n % 2);
        logic w0, w1, r0, r1;

        // Fixed priority: even write, odd write, even read, odd read.
        assign w0 = wr_pend_vld[C0] && (wr_pend_bank[C0] == BSEL);
        assign w1 = wr_pend_vld[C1] && (wr_pend_bank[C1] == BSEL);
        assign r0 = rd_hit[C0] && (rd_cmd_in[C0].channel_id == BSEL);
        assign r1 = rd_hit[C1] && (rd_cmd_in[C1].channel_id == BSEL);

        assign bank_we[n]   = w0 | w1;
        assign bank_en[n]   = w0 | w1 | r0 | r1;
        assign bank_addr[n] = w0 ? wr_pend_addr[C0] :
                              w1 ? wr_pend_addr[C1] :
                              r0 ? rd_cmd_in[C0].addr[ADDR_W-1:0] :
                                   rd_cmd_in[C1].addr[ADDR_W-1:0];
        assign bank_wdat[n] = w0 ? wr_data_in[C0] : wr_data_in[C1];
        assign wr_lose[n]   = w0 & w1;
        assign gnt_even[n]  = r0 & ~(w0 | w1);
        assign gnt_odd[n]   = r1 & ~(w0 | w1) & ~r0;

        vec_cache_sram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank (
            .clk   (clk),
            .en    (bank_en[n]),
            .we    (bank_we[n]),
            .addr  (bank_addr[n]),
            .wdata (bank_wdat[n]),
            .rdata (bank_rdat[n])
        );
    end

    always_comb begin
        rd_gnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            chan_dout[c] = bank_rdat[bank_of(c, p_cmd[0][c].channel_id)];
            if (c % 2 == 0) rd_gnt[c] = gnt_even[bank_of(c, rd_cmd_in[c].channel_id)];
            else            rd_gnt[c] = gnt_odd[bank_of(c, rd_cmd_in[c].channel_id)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) p_vld[k] <= '0;
        end else begin
            p_vld[0] <= rd_hit;
            for (int k = 1; k < RD_LAT; k++) p_vld[k] <= p_vld[k-1];
        end
    end

    always_ff @(posedge clk) begin
        p_gnt[0] <= rd_gnt;
        p_cmd[0] <= rd_cmd_in;
        for (int k = 1; k < RD_LAT; k++) begin
            p_gnt[k] <= p_gnt[k-1];
            p_cmd[k] <= p_cmd[k-1];
        end
    end

    // Bank data is valid one cycle after the command; carry it through the remaining stages.
    if (RD_LAT == 1) begin : g_lat1
        assign out_dat = chan_dout;
    end else begin : g_latn
        logic [DATA_W-1:0] dat_q [RD_LAT-1][NUM_CH];
        always_ff @(posedge clk) begin
            dat_q[0] <= chan_dout;
            for (int j = 1; j < RD_LAT - 1; j++) dat_q[j] <= dat_q[j-1];
        end
        assign out_dat = dat_q[RD_LAT-2];
    end

    assign loc_vld         = p_vld[RD_LAT-1];
    assign loc_gnt         = p_gnt[RD_LAT-1];
    assign slot_coll       = loc_vld & rd_data_vld_in;
    assign rd_data_vld_out = loc_vld | rd_data_vld_in;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            rd_data_out[c]     = rd_data_in[c];
            rd_data_cmd_out[c] = rd_data_cmd_in[c];
            rd_data_err_out[c] = rd_data_err_in[c];
            if (loc_vld[c]) begin
                rd_data_out[c]     = loc_gnt[c] ? out_dat[c] : '0;
                rd_data_cmd_out[c] = p_cmd[RD_LAT-1][c];
                rd_data_err_out[c] = ~loc_gnt[c];
            end
        end
    end

    always_comb begin
        coll_nxt = '0;
        for (int i = 0; i < NPAIR; i++) begin
            coll_nxt[i] = wr_lose[2*i] | wr_lose[2*i+1] | slot_coll[2*i] | slot_coll[2*i+1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision  <= '0;
            err_sticky <= 1'b0;
        end else begin
            collision <= coll_nxt;
            if (|collision)   err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_cache_mem_slice.sv
// Randomized and directed bench for vec_cache_mem_slice against a cycle-level reference model.
module tb_vec_cache_mem_slice;
    import vector_cache_pkg::*;

    localparam int NCH = 8;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int LAT = 3;
    localparam int BID = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NCH-1:0]   rd_cmd_vld_in, rd_cmd_vld_out, wr_cmd_vld_in, wr_cmd_vld_out;
    mem_cmd_t         rd_cmd_in [NCH], rd_cmd_out [NCH], wr_cmd_in [NCH], wr_cmd_out [NCH];
    logic [NCH-1:0]   wr_data_vld_in, wr_data_vld_out;
    logic [DW-1:0]    wr_data_in [NCH], wr_data_out [NCH];
    logic [NCH-1:0]   rd_data_vld_in, rd_data_err_in, rd_data_vld_out, rd_data_err_out;
    logic [DW-1:0]    rd_data_in [NCH], rd_data_out [NCH];
    mem_cmd_t         rd_data_cmd_in [NCH], rd_data_cmd_out [NCH];
    logic [NCH/2-1:0] collision;
    logic             err_sticky, err_clr;

    vec_cache_mem_slice #(.BLOCK_ID(BID), .NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .rd_cmd_vld_in(rd_cmd_vld_in), .rd_cmd_in(rd_cmd_in),
        .rd_cmd_vld_out(rd_cmd_vld_out), .rd_cmd_out(rd_cmd_out),
        .wr_cmd_vld_in(wr_cmd_vld_in), .wr_cmd_in(wr_cmd_in),
        .wr_cmd_vld_out(wr_cmd_vld_out), .wr_cmd_out(wr_cmd_out),
        .wr_data_vld_in(wr_data_vld_in), .wr_data_in(wr_data_in),
        .wr_data_vld_out(wr_data_vld_out), .wr_data_out(wr_data_out),
        .rd_data_vld_in(rd_data_vld_in), .rd_data_in(rd_data_in),
        .rd_data_cmd_in(rd_data_cmd_in), .rd_data_err_in(rd_data_err_in),
        .rd_data_vld_out(rd_data_vld_out), .rd_data_out(rd_data_out),
        .rd_data_cmd_out(rd_data_cmd_out), .rd_data_err_out(rd_data_err_out),
        .collision(collision), .err_sticky(err_sticky), .err_clr(err_clr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference state: bank contents (addresses 0..7), pending write beats, scheduled completions.
    logic [DW-1:0] m_mem [NCH][8];
    bit            pw_vld [NCH];
    bit            pw_bank [NCH];
    int            pw_addr [NCH];
    bit            sch_vld [8][NCH];
    bit            sch_err [8][NCH];
    logic [DW-1:0] sch_dat [8][NCH];
    mem_cmd_t      sch_cmd [8][NCH];
    bit [3:0]      coll_q;
    bit            sticky_q;
    int            cyc = 0;

    function automatic mem_cmd_t mk_cmd(input mem_opcode_e op, input int bid, input int ch, input int addr);
        mem_cmd_t m;
        m.opcode     = op;
        m.block_id   = BLOCK_ID_W'(bid);
        m.channel_id = CHAN_ID_W'(ch);
        m.addr       = CMD_ADDR_W'(addr);
        m.txnid      = TXNID_W'($urandom);
        return m;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            pw_vld[c] = 0;
            for (int s = 0; s < 8; s++) sch_vld[s][c] = 0;
        end
        coll_q   = '0;
        sticky_q = 0;
    endtask

    task automatic idle();
        rd_cmd_vld_in = '0; wr_cmd_vld_in = '0; wr_data_vld_in = '0;
        rd_data_vld_in = '0; rd_data_err_in = '0; err_clr = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            rd_cmd_in[c] = '0; wr_cmd_in[c] = '0; wr_data_in[c] = '0;
            rd_data_in[c] = '0; rd_data_cmd_in[c] = '0;
        end
    endtask

    // Called at posedge+1 with inputs applied; checks mid-cycle, then advances the model one cycle.
    task automatic step();
        int slot, due, wch, kch;
        bit [3:0] coll_n;
        logic [NCH-1:0] exp_v;
        bit present, is_wr;
        int winner;
        #4;
        slot   = cyc % 8;
        due    = (cyc + LAT) % 8;
        coll_n = '0;

        exp_v = '0;
        for (int c = 0; c < NCH; c++) exp_v[c] = rd_cmd_vld_in[c] && (rd_cmd_in[c].block_id != BID);
        chk("rd_cmd_vld_out", rd_cmd_vld_out, exp_v);
        for (int c = 0; c < NCH; c++) if (exp_v[c]) chk("rd_cmd_out", rd_cmd_out[c], rd_cmd_in[c]);
        exp_v = '0;
        for (int c = 0; c < NCH; c++) exp_v[c] = wr_cmd_vld_in[c] && (wr_cmd_in[c].block_id != BID);
        chk("wr_cmd_vld_out", wr_cmd_vld_out, exp_v);
        for (int c = 0; c < NCH; c++) if (exp_v[c]) chk("wr_cmd_out", wr_cmd_out[c], wr_cmd_in[c]);
        exp_v = '0;
        for (int c = 0; c < NCH; c++) exp_v[c] = wr_data_vld_in[c] && !pw_vld[c];
        chk("wr_data_vld_out", wr_data_vld_out, exp_v);
        for (int c = 0; c < NCH; c++) if (exp_v[c]) chk("wr_data_out", wr_data_out[c], wr_data_in[c]);

        exp_v = '0;
        for (int c = 0; c < NCH; c++) exp_v[c] = sch_vld[slot][c] || rd_data_vld_in[c];
        chk("rd_data_vld_out", rd_data_vld_out, exp_v);
        for (int c = 0; c < NCH; c++) begin
            if (sch_vld[slot][c]) begin
                chk("local_data", rd_data_out[c], sch_dat[slot][c]);
                chk("local_cmd", rd_data_cmd_out[c], sch_cmd[slot][c]);
                chk("local_err", rd_data_err_out[c], sch_err[slot][c]);
                if (rd_data_vld_in[c]) coll_n[c/2] = 1;
            end else if (rd_data_vld_in[c]) begin
                chk("pass_data", rd_data_out[c], rd_data_in[c]);
                chk("pass_cmd", rd_data_cmd_out[c], rd_data_cmd_in[c]);
                chk("pass_err", rd_data_err_out[c], rd_data_err_in[c]);
            end
            sch_vld[slot][c] = 0;
        end
        chk("collision", collision, coll_q);
        chk("err_sticky", err_sticky, sticky_q);

        // Each bank: walk the four requesters in priority order; the first present one wins.
        for (int n = 0; n < NCH; n++) begin
            winner = -1;
            wch    = 0;
            for (int k = 0; k < 4; k++) begin
                kch   = (n / 2) * 2 + k % 2;
                is_wr = (k < 2);
                if (is_wr) present = pw_vld[kch] && (int'(pw_bank[kch]) == n % 2);
                else       present = rd_cmd_vld_in[kch] && (rd_cmd_in[kch].block_id == BID) &&
                                     (int'(rd_cmd_in[kch].channel_id) == n % 2);
                if (present) begin
                    if (winner < 0) begin
                        winner = k;
                        if (is_wr) wch = kch;
                    end else if (is_wr) begin
                        coll_n[n/2] = 1;
                    end
                    if (!is_wr) begin
                        sch_vld[due][kch] = 1;
                        sch_cmd[due][kch] = rd_cmd_in[kch];
                        sch_err[due][kch] = (winner != k);
                        sch_dat[due][kch] = (winner == k) ? m_mem[n][rd_cmd_in[kch].addr[2:0]] : '0;
                    end
                end
            end
            if (winner == 0 || winner == 1) m_mem[n][pw_addr[wch]] = wr_data_in[wch];
        end

        for (int c = 0; c < NCH; c++) begin
            pw_vld[c]  = wr_cmd_vld_in[c] && (wr_cmd_in[c].block_id == BID);
            pw_bank[c] = wr_cmd_in[c].channel_id[0];
            pw_addr[c] = int'(wr_cmd_in[c].addr[2:0]);
        end
        sticky_q = (coll_q != 0) || (sticky_q && !err_clr);
        coll_q   = coll_n;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_clear();
        #23 rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) step();

        // Fill addresses 0..7 of every bank; even channels bank 0, odd channels bank 1.
        for (int a = 0; a <= 8; a++) begin
            idle();
            for (int c = 0; c < NCH; c++) begin
                if (a < 8) begin
                    wr_cmd_vld_in[c] = 1'b1;
                    wr_cmd_in[c]     = mk_cmd(OP_WR, BID, c % 2, a);
                end
                if (a > 0) begin
                    wr_data_vld_in[c] = 1'b1;
                    wr_data_in[c]     = $urandom;
                end
            end
            step();
        end

        // Read hit after write.
        idle(); wr_cmd_vld_in[0] = 1'b1; wr_cmd_in[0] = mk_cmd(OP_WR, BID, 0, 5); step();
        idle(); wr_data_vld_in[0] = 1'b1; wr_data_in[0] = 32'hA5A5_0001; step();
        idle(); step();
        idle(); rd_cmd_vld_in[0] = 1'b1; rd_cmd_in[0] = mk_cmd(OP_RD, BID, 0, 5); step();
        idle(); step(); step();
        chk("hit_vld", rd_data_vld_out[0], 1'b1);
        chk("hit_data", rd_data_out[0], 32'hA5A5_0001);
        chk("hit_err", rd_data_err_out[0], 1'b0);
        step();

        // Miss passthrough.
        idle(); rd_cmd_vld_in[3] = 1'b1; rd_cmd_in[3] = mk_cmd(OP_RD, 1, 1, 4); step();
        idle(); repeat (3) step();

        // Read conflict on pair 1 bank 1.
        idle();
        rd_cmd_vld_in[2] = 1'b1; rd_cmd_in[2] = mk_cmd(OP_RD, BID, 1, 3);
        rd_cmd_vld_in[3] = 1'b1; rd_cmd_in[3] = mk_cmd(OP_RD, BID, 1, 3);
        step();
        idle(); step(); step();
        chk("conflict_err2", rd_data_err_out[2], 1'b0);
        chk("conflict_err3", rd_data_err_out[3], 1'b1);
        chk("conflict_dat3", rd_data_out[3], 32'h0);
        step();

        // Write collision on pair 2 bank 0.
        idle();
        wr_cmd_vld_in[4] = 1'b1; wr_cmd_in[4] = mk_cmd(OP_WR, BID, 0, 6);
        wr_cmd_vld_in[5] = 1'b1; wr_cmd_in[5] = mk_cmd(OP_WR, BID, 0, 6);
        step();
        idle();
        wr_data_vld_in[4] = 1'b1; wr_data_in[4] = 32'h1111_2222;
        wr_data_vld_in[5] = 1'b1; wr_data_in[5] = 32'h3333_4444;
        step();
        idle();
        chk("wcoll_pulse", collision, 4'b0100);
        rd_cmd_vld_in[4] = 1'b1; rd_cmd_in[4] = mk_cmd(OP_RD, BID, 0, 6);
        step();
        idle(); step(); step();
        chk("wcoll_stored", rd_data_out[4], 32'h1111_2222);
        chk("wcoll_sticky", err_sticky, 1'b1);
        step();
        idle(); err_clr = 1'b1; step();
        idle(); step();
        chk("sticky_cleared", err_sticky, 1'b0);

        // Slot collision on channel 6.
        idle(); rd_cmd_vld_in[6] = 1'b1; rd_cmd_in[6] = mk_cmd(OP_RD, BID, 0, 1); step();
        idle(); step(); step();
        rd_data_vld_in[6] = 1'b1; rd_data_in[6] = 32'hDEAD_BEEF;
        rd_data_cmd_in[6] = mk_cmd(OP_RD, 7, 1, 2);
        step();
        idle(); step();
        idle(); err_clr = 1'b1; step();

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            idle();
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rd_cmd_vld_in[c] = 1'b1;
                    rd_cmd_in[c] = mk_cmd(OP_RD, ($urandom_range(0, 3) != 0) ? BID : int'($urandom_range(0, 15)),
                                          int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
                end
                if ($urandom_range(0, 4) == 0) begin
                    wr_cmd_vld_in[c] = 1'b1;
                    wr_cmd_in[c] = mk_cmd(OP_WR, ($urandom_range(0, 3) != 0) ? BID : int'($urandom_range(0, 15)),
                                          int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
                end
                wr_data_vld_in[c] = pw_vld[c] || ($urandom_range(0, 5) == 0);
                wr_data_in[c]     = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    rd_data_vld_in[c] = 1'b1;
                    rd_data_in[c]     = $urandom;
                    rd_data_err_in[c] = 1'($urandom_range(0, 1));
                    rd_data_cmd_in[c] = mk_cmd(OP_RD, int'($urandom_range(0, 15)), 0, int'($urandom_range(0, 7)));
                end
            end
            err_clr = ($urandom_range(0, 9) == 0);
            step();
        end

        // Reset with two reads in flight.
        idle();
        rd_cmd_vld_in[0] = 1'b1; rd_cmd_in[0] = mk_cmd(OP_RD, BID, 0, 1);
        rd_cmd_vld_in[1] = 1'b1; rd_cmd_in[1] = mk_cmd(OP_RD, BID, 1, 2);
        step();
        idle();
        #1 rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int t = 0; t < 6; t++) begin
            chk("post_reset_vld", rd_data_vld_out, '0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
